// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-master round-robin data-memory port arbiter with an
//                M1 burst lock bounded by a starvation watchdog.
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] c_max_lock = 8'(MAX_LOCK);

  typedef enum logic [0:0] {
    ST_RR   = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_last_gnt;
  logic [7:0]  r_lock_cnt;
  logic        r_rd_pend;
  logic        r_resp_id;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any_gnt;
  logic [7:0]  w_lock_cnt_nxt;
  logic        w_max_hit;

  // Grants are gated by reset so every output is quiet while rst is low.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
      if (r_state == ST_LOCK) begin
        if (m1_req)      w_gnt1 = 1'b1;
        else if (m0_req) w_gnt0 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (r_last_gnt) w_gnt0 = 1'b1;
        else            w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  always_comb begin
    mem_en    = w_any_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wstrb = m0_wstrb;
    end else if (w_gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wstrb = m1_wstrb;
    end
  end

  // Watchdog only runs while M0 is actually waiting on a locked M1.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (!m0_req)     w_lock_cnt_nxt = 8'd0;
    else if (w_gnt1) w_lock_cnt_nxt = r_lock_cnt + 8'd1;
  end

  assign w_max_hit = (w_lock_cnt_nxt >= c_max_lock);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RR;
      r_last_gnt <= 1'b1;
      r_lock_cnt <= 8'd0;
      r_rd_pend  <= 1'b0;
      r_resp_id  <= 1'b0;
    end else begin
      r_rd_pend <= w_any_gnt && !mem_we;
      if (w_any_gnt) begin
        r_last_gnt <= w_gnt1;
        r_resp_id  <= w_gnt1;
      end
      case (r_state)
        ST_RR: begin
          r_lock_cnt <= 8'd0;
          if (w_gnt1 && m1_lock) r_state <= ST_LOCK;
        end
        ST_LOCK: begin
          if (!m1_req || !m1_lock || w_max_hit) begin
            r_state    <= ST_RR;
            r_lock_cnt <= 8'd0;
            if (w_max_hit) r_last_gnt <= 1'b1;
          end else begin
            r_lock_cnt <= w_lock_cnt_nxt;
          end
        end
        default: begin
          r_state    <= ST_RR;
          r_lock_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rd_pend && !r_resp_id;
  assign m1_rvalid = r_rd_pend &&  r_resp_id;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire
